// File: rtl/fp_divide_6bit_pkg.sv
// Shared constants and state encoding for the 6-bit mantissa / 5-bit exponent divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_divide_6bit_pkg;

    localparam int MW_DEF = 6;           // mantissa width
    localparam int EW_DEF = 5;           // exponent width
    localparam int QW_DEF = 2 * MW_DEF;  // quotient width, one CALC step per bit

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A new request may be taken whenever no division is in flight,
    // including the cycle that presents the previous result.
    function automatic logic can_accept(input state_t s);
        return (s != ST_CALC);
    endfunction

endpackage

// File: rtl/fp_divide_6bit_div_restore_step.sv
// One restoring-division step: shift next dividend bit into R, subtract B if it fits.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   r      in   MW+1  partial remainder before this step (always < B)
//   d_msb  in   1     next dividend bit, MSB first
//   b      in   MW    divisor mantissa (non-zero)
//   r_next out  MW+1  partial remainder after this step
//   q_bit  out  1     quotient bit produced by this step
module div_restore_step #(
    parameter int MW = 6
) (
    input  logic [MW:0]   r,
    input  logic          d_msb,
    input  logic [MW-1:0] b,
    output logic [MW:0]   r_next,
    output logic          q_bit
);

    // R < B <= 2^MW-1 holds between steps, so r[MW] is always 0 and the
    // widened {r, d_msb} equals the architectural {r[MW-1:0], d_msb}.
    // Either result below is < 2^(MW+1), so truncating to MW+1 bits is exact.
    logic [MW+1:0] r_shift;
    logic [MW+1:0] b_ext;

    always_comb begin
        r_shift = {r, d_msb};
        b_ext   = (MW+2)'(b);
        r_next  = (MW+1)'(r_shift);
        q_bit   = 1'b0;
        if (r_shift >= b_ext) begin
            r_next = (MW+1)'(r_shift - b_ext);
            q_bit  = 1'b1;
        end
    end

endmodule

// File: rtl/fp_divide_6bit.sv
// Sign/exponent/mantissa divider A/B: 6.6 fixed-point quotient by restoring division.
// Latency: Done 13 cycles after an accepted Start (1 cycle when MantissaB == 0).
// Backpressure: Start is taken only while Busy=0; a Start during Busy is dropped, not queued.
//
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   Start                   request, sampled when Busy=0
//   SignA/B, ExponentA/B,   operand fields (latched on accept)
//   MantissaA/B
//   Busy                    division steps in progress
//   Done                    one-cycle pulse, result fields valid
//   SignOut, ExponentOut,   result registers, updated only when entering DONE
//   ExponentC, QuotientOut,
//   RemainderOut, DivByZero
module fp_divide_6bit
    import fp_divide_6bit_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Start,
    input  logic              SignA,
    input  logic              SignB,
    input  logic [EW-1:0]     ExponentA,
    input  logic [EW-1:0]     ExponentB,
    input  logic [MW-1:0]     MantissaA,
    input  logic [MW-1:0]     MantissaB,
    output logic              Busy,
    output logic              Done,
    output logic              SignOut,
    output logic [EW:0]       ExponentOut,
    output logic              ExponentC,
    output logic [2*MW-1:0]   QuotientOut,
    output logic [MW-1:0]     RemainderOut,
    output logic              DivByZero
);

    localparam int QW = 2 * MW;
    localparam logic [3:0] LAST_STEP = 4'(QW - 1);

    // FSM and datapath state
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [MW:0]     r_q, r_d;
    // Dividend shift register; quotient bits enter at the LSB as dividend
    // bits leave at the MSB, so after QW steps it holds the full quotient.
    logic [QW-1:0]   d_q, d_d;
    logic [MW-1:0]   b_q, b_d;
    logic            sign_q, sign_d;
    logic [EW:0]     exp_q, exp_d;

    // Result registers
    logic            sign_out_q, sign_out_d;
    logic [EW:0]     exp_out_q, exp_out_d;
    logic [QW-1:0]   quot_q, quot_d;
    logic [MW-1:0]   rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [MW:0]     step_r_next;
    logic            step_q_bit;
    logic [EW:0]     exp_in_diff;

    div_restore_step #(
        .MW(MW)
    ) u_step (
        .r      (r_q),
        .d_msb  (d_q[QW-1]),
        .b      (b_q),
        .r_next (step_r_next),
        .q_bit  (step_q_bit)
    );

    // Zero-extended subtraction: bit EW doubles as the borrow flag.
    assign exp_in_diff = {1'b0, ExponentA} - {1'b0, ExponentB};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        d_d        = d_q;
        b_d        = b_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        sign_out_d = sign_out_q;
        exp_out_d  = exp_out_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        case (state_q)
            ST_CALC: begin
                r_d   = step_r_next;
                d_d   = {d_q[QW-2:0], step_q_bit};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d    = ST_DONE;
                    sign_out_d = sign_q;
                    exp_out_d  = exp_q;
                    quot_d     = {d_q[QW-2:0], step_q_bit};
                    rem_d      = step_r_next[MW-1:0];
                    dbz_d      = 1'b0;
                end
            end

            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (Start && can_accept(state_q)) begin
                    sign_d = SignA ^ SignB;
                    exp_d  = exp_in_diff;
                    b_d    = MantissaB;
                    if (MantissaB != '0) begin
                        state_d = ST_CALC;
                        cnt_d   = 4'd0;
                        r_d     = '0;
                        d_d     = {MantissaA, {MW{1'b0}}};
                    end else begin
                        // No steps to run: publish the saturated result now.
                        state_d    = ST_DONE;
                        sign_out_d = SignA ^ SignB;
                        exp_out_d  = exp_in_diff;
                        quot_d     = '1;
                        rem_d      = '0;
                        dbz_d      = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            d_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            sign_out_q <= 1'b0;
            exp_out_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            d_q        <= d_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            sign_out_q <= sign_out_d;
            exp_out_q  <= exp_out_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
        end
    end

    assign Busy         = (state_q == ST_CALC);
    assign Done         = (state_q == ST_DONE);
    assign SignOut      = sign_out_q;
    assign ExponentOut  = exp_out_q;
    assign ExponentC    = exp_out_q[EW];
    assign QuotientOut  = quot_q;
    assign RemainderOut = rem_q;
    assign DivByZero    = dbz_q;

endmodule
